sram_controller: RTL and testbench
==================================

Name: sram_controller

Overview:
- Memory-side responder for the MEM stage's data-memory requests; replaces the on-chip data memory with the DE2 external 16-bit SRAM.
- Accepts one 32-bit word read or write per request from the pipeline and splits it into two 16-bit SRAM accesses, low half first.
- Drops `ready` while busy; the hazard/freeze logic uses this to stall the whole pipeline until the access completes.

Parameters:
- BASE_ADDR, 1024, byte address of data-memory word 0; subtracted from the CPU address before mapping.
- SRAM_WAIT, 2, cycles each 16-bit phase is held; legal range 2..15.

Ports:
- clk  input  1  system clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  MEM-stage store request; level, held until ready=1.
- rd_en  input  1  MEM-stage load request; level, held until ready=1.
- address  input  32  byte address from the EXE result; bits [1:0] ignored.
- write_data  input  32  store data, used only when wr_en=1.
- read_data  output  32  load result, registered.
- ready  output  1  1 = idle or access completing this cycle; 0 = stall pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  SRAM write enable, active low.
- SRAM_OE_N  output  1  SRAM output enable, active low.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0.

Behaviour:
- Single clock, clk; reset synchronous active-high on rst.
- Reset values:
  - state = IDLE; counter = 0; read_data = 0; SRAM_ADDR = 0.
  - SRAM_WE_N = 1; SRAM_OE_N = 0; SRAM_DQ = Z.
- Address map:
  - word = (address - BASE_ADDR) >> 2, truncated to 17 bits.
  - The low half is at SRAM_ADDR = {word, 1'b0}; the high half is at {word, 1'b1}.
  - Addresses below BASE_ADDR wrap modulo 2^18 halfwords; no error is flagged.
- `ready` is combinational:
  - In IDLE: ready = ~(rd_en | wr_en), so the stall is seen in the request cycle.
  - In LOW and HIGH: ready = 0.
  - In DONE: ready = 1.
- If rd_en and wr_en are both 1, the access is treated as a write.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: on request, latch address, write_data and the op; go to LOW with counter = 0.
  - LOW: drive the low-half address. Stay SRAM_WAIT cycles (counter 0..SRAM_WAIT-1), then go to HIGH with counter = 0.
  - HIGH: same as LOW for the high half; then go to DONE.
  - DONE: one cycle. Unconditionally go to IDLE, even if requests are still asserted, because the pipeline advances on this edge and a repeat access is forbidden.
- Write phase:
  - SRAM_DQ drives the latched data half ([15:0] in LOW, [31:16] in HIGH).
  - SRAM_WE_N = 0 while counter < SRAM_WAIT-1 and 1 on the last cycle of the phase, so address and data are stable across the WE_N rising edge.
- Read phase:
  - SRAM_DQ = Z and SRAM_WE_N = 1.
  - SRAM_DQ is sampled on the last cycle of the phase into the low or high half of read_data.
- read_data holds its value until the next read completes; writes never change it.
- Latency from the request cycle (cycle 0):
  - LOW spans cycles 1..W, HIGH spans cycles W+1..2W, DONE is cycle 2W+1; ready is low for cycles 0..2W.
  - With W = 2: stall for 5 cycles, ready = 1 at cycle 5.
- Outside write phases SRAM_DQ is always Z; SRAM_ADDR holds its last value.
- rst asserted mid-access: the next state is IDLE with WE_N = 1, DQ = Z and read_data = 0. A partially written word is left as is.

Decomposition:
- Shared package `arm_pkg`:
  - state enum sram_state_t {IDLE, LOW, HIGH, DONE}.
  - localparam DATA_MEM_BASE = 1024.
  - SRAM_ADDR_W = 18; SRAM_DATA_W = 16.
- No RTL sub-module is needed; the tristate is a single continuous assign.
- A behavioural SRAM model (`sram_model`) is a sim-only companion for the bench.

Test Plan:
1. Reset: rst=1 for 2 cycles, no requests -> ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
2. Write: wr_en, address=1024, write_data=0xDEADBEEF -> ready=0 for cycles 0-4, =1 at cycle 5. SRAM_ADDR=0 with DQ=0xBEEF in cycles 1-2, then SRAM_ADDR=1 with DQ=0xDEAD in cycles 3-4. WE_N=0 only in cycles 1 and 3.
3. Read back: rd_en, address=1024 -> ready=1 at cycle 5 with read_data=0xDEADBEEF. Also write 0x12345678 at 1028, then read 1031 -> halfwords 2 and 3 accessed, read_data=0x12345678.
4. Simultaneous rd_en=wr_en=1, address=1032, data=0xCAFEF00D -> write performed; read_data unchanged; a later read of 1032 returns 0xCAFEF00D.
5. Back-to-back: rd_en held high across DONE for two pipelined loads -> exactly two 5-cycle accesses, with a single ready=1 cycle between them. No duplicate access is issued in DONE.
6. Reset mid-write: rst=1 in the first HIGH cycle -> next cycle is IDLE, WE_N=1, DQ=Z, ready=~request. A subsequent full write and read of 1024 is correct.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the data-memory path: SRAM controller states and bus geometry.
// Imported by the controller.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    localparam int unsigned DATA_MEM_BASE = 1024;
    localparam int          SRAM_ADDR_W   = 18;
    localparam int          SRAM_DATA_W   = 16;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases (low half first).
// Latency 2*SRAM_WAIT+1 cycles from request; ready stays low until DONE to freeze the pipeline.
module sram_controller
    import arm_pkg::*;
#(
    parameter int unsigned BASE_ADDR = DATA_MEM_BASE,
    parameter int unsigned SRAM_WAIT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);

    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

    sram_state_t            state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   op_wr_q, op_wr_d;
    logic [16:0]            word_q, word_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [15:0]            rd_lo_q, rd_lo_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;

    logic [31:0] offset;
    logic        unused_offset_bits;
    logic        phase_last;
    logic        drive_dq;

    assign offset             = address - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_wr_d     = op_wr_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        rd_lo_d     = rd_lo_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        ready       = 1'b0;

        phase_last = (cnt_q == LAST);
        drive_dq   = op_wr_q && (state_q == LOW || state_q == HIGH);

        unique case (state_q)
            IDLE: begin
                ready = ~(rd_en | wr_en);
                if (rd_en || wr_en) begin
                    op_wr_d     = wr_en;
                    word_d      = offset[18:2];
                    wdata_d     = write_data;
                    cnt_d       = 4'd0;
                    sram_addr_d = {offset[18:2], 1'b0};
                    state_d     = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    cnt_d       = 4'd0;
                    sram_addr_d = {word_q, 1'b1};
                    state_d     = HIGH;
                    if (!op_wr_q) rd_lo_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    // Update read_data in one shot so it only changes when a read completes.
                    if (!op_wr_q) read_data_d = {SRAM_DQ, rd_lo_q};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Never re-arm here: the pipeline advances on this edge with the request still up.
                ready   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            rd_lo_q     <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_wr_q     <= op_wr_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            rd_lo_q     <= rd_lo_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    // WE_N rises on the last phase cycle while address and data are still held.
    assign SRAM_WE_N = ~(drive_dq && (cnt_q < LAST));
    assign SRAM_OE_N = drive_dq;
    assign SRAM_DQ   = drive_dq ? ((state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0])
                                : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed plus random load/store sequence against the controller, with an inline SRAM array
// and a reference memory keyed by halfword address.
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    int n_cmp = 0;
    int n_err = 0;

    sram_controller #(.BASE_ADDR(1024), .SRAM_WAIT(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OE_N  (sram_oe_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n)
    );

    always #5 clk = ~clk;

    // External SRAM: drives the bus on reads, captures on any clock with WE_N low.
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'bz;
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;

    // Reference memory: halfword index -> contents; untouched locations hold the power-up pattern.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] init_pat(input int h);
        return 16'(h) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_rd(input int h);
        return ref_mem.exists(h) ? ref_mem[h] : init_pat(h);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
        logic [31:0] ofs;
        logic [16:0] w;
        logic [31:0] old_rd;
        logic        hi;
        int          pos;
        int          lo_h, hi_h;
        ofs  = a - 32'd1024;
        w    = ofs[18:2];
        lo_h = int'({w, 1'b0});
        hi_h = int'({w, 1'b1});
        @(posedge clk); #1;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        old_rd = read_data;
        for (int c = 0; c <= 2 * W; c++) begin
            @(negedge clk);
            chk("stall_ready", ready, 0);
            if (c >= 1) begin
                hi  = (c > W);
                pos = (c - 1) % W;
                chk("sram_addr", sram_addr, {w, hi});
                chk("we_n", sram_we_n, (wr && pos < W - 1) ? 1'b0 : 1'b1);
                if (wr) chk("wr_dq", sram_dq, hi ? d[31:16] : d[15:0]);
            end
        end
        @(negedge clk);
        chk("done_ready", ready, 1);
        if (wr) begin
            chk("rd_hold_on_write", read_data, old_rd);
            ref_mem[lo_h] = d[15:0];
            ref_mem[hi_h] = d[31:16];
        end else begin
            chk("rd_data", read_data, {ref_rd(hi_h), ref_rd(lo_h)});
        end
        if (!hold) begin
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, d;
        int          op;
        for (int i = 0; i < 262144; i++) sram_mem[i] = init_pat(i);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 0);
        chk("rst_dq_float", sram_dq, init_pat(0));
        chk("rst_read_data", read_data, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("tied_ce_ub_lb", {sram_ce_n, sram_ub_n, sram_lb_n}, 0);

        // Write then read back, plus an unaligned read of a second word
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 1'b0);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        chk("readback_deadbeef", read_data, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 32'd1028, 32'h12345678, 1'b0);
        do_access(1'b0, 1'b1, 32'd1031, 32'h0, 1'b0);
        chk("readback_12345678", read_data, 32'h12345678);

        // Both strobes: treated as a write
        do_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b0);
        chk("both_keeps_rd", read_data, 32'h12345678);
        do_access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0);
        chk("readback_cafef00d", read_data, 32'hCAFEF00D);

        // Back-to-back loads with rd_en held through DONE
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        chk("b2b_second", read_data, 32'h12345678);

        // Reset during the first HIGH cycle of a write
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1024; write_data = 32'h0BADF00D;
        repeat (W + 1) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_high_addr", sram_addr, 1);
        ref_mem[0] = 16'hF00D;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ready", ready, 0);
        chk("midrst_we_n", sram_we_n, 1);
        chk("midrst_dq_float", sram_dq, ref_rd(0));
        chk("midrst_read_data", read_data, 0);
        chk("midrst_addr", sram_addr, 0);
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ready", ready, 1);
        do_access(1'b1, 1'b0, 32'd1024, 32'h89ABCDEF, 1'b0);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        chk("midrst_readback", read_data, 32'h89ABCDEF);

        // Random mix, including addresses below the base that wrap
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1023);
            else a = 32'd1024 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            d  = $urandom;
            op = $urandom_range(0, 3);
            do_access(op >= 2, op != 2, a, d, bit'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        chk("final_idle_ready", ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
